// File: rtl/lock_pkg.sv
// lock_pkg: keypad scanner state encoding, key codes and keymap helpers shared with the lock.
package lock_pkg;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} kp_state_e;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] digit;
        digit = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        return (row == 2'd3) ? ((col == 2'd0) ? KEY_STAR : (col == 2'd1) ? 4'd0 :
                                (col == 2'd2) ? KEY_HASH : KEY_D)
             : (col == 2'd3) ? KEY_A + 4'(row) : digit;
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rs);
        return !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [1:0] col_idx(input logic [3:0] col_n);
        return !col_n[0] ? 2'd0 : !col_n[1] ? 2'd1 : !col_n[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// keypad_sync2: 4-bit two-flop synchronizer for the active-low keypad rows, resets to idle (all ones).
module keypad_sync2 (
    input  logic       hwclk,
    input  logic       reset_n,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] s1_q, s2_q;

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 4'hF;
            s2_q <= 4'hF;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, single-key debounce and encode for the lock.
// Optional GHOST_REJECT_EN: reject multi-row samples instead of using lowest-row priority.
module keypad_scanner
    import lock_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1200,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       hwclk,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_strobe
);

    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    kp_state_e     state_q;
    logic [3:0]    rs, col_q, rows_q, button_q;
    logic [1:0]    row_q;
    logic [SW-1:0] slot_q;
    logic [DW-1:0] deb_q;
    logic          bstate_q, strobe_q, scan_hit, row_low;

    keypad_sync2 u_sync (
        .hwclk  (hwclk),
        .reset_n(reset_n),
        .d_i    (row_n),
        .q_o    (rs)
    );

    assign row_low = !rs[row_q];
`ifdef GHOST_REJECT_EN
    logic other_low;
    assign scan_hit  = (rs != 4'hF) && ($countones(~rs) == 1);
    assign other_low = |(~rs & ~(4'b0001 << row_q));
`else
    assign scan_hit  = rs != 4'hF;
`endif

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SCAN;
            col_q    <= 4'b1110;
            rows_q   <= 4'hF;
            row_q    <= 2'd0;
            slot_q   <= '0;
            deb_q    <= '0;
            button_q <= 4'd0;
            bstate_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                SCAN: begin
`ifdef GHOST_REJECT_EN
                    // A ghost knocked us out of HELD: the release still goes through DEB_REL
                    if (bstate_q) begin
                        if (rs == 4'hF) begin
                            state_q <= DEB_REL;
                            deb_q   <= '0;
                        end
                    end else
`endif
                    if (slot_q != SLOT_LAST) begin
                        slot_q <= slot_q + 1'b1;
                    end else if (scan_hit) begin
                        slot_q  <= '0;
                        rows_q  <= rs;
                        row_q   <= low_row(rs);
                        deb_q   <= '0;
                        state_q <= DEB_PRESS;
                    end else begin
                        slot_q <= '0;
                        col_q  <= {col_q[2:0], col_q[3]};
                    end
                end
                DEB_PRESS: begin
                    if (rs != rows_q) begin
                        state_q <= SCAN;
                        slot_q  <= '0;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q  <= HELD;
                        deb_q    <= '0;
                        button_q <= key_code(row_q, col_idx(col_q));
                        bstate_q <= 1'b1;
                        strobe_q <= 1'b1;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                HELD: begin
`ifdef GHOST_REJECT_EN
                    if (other_low) begin
                        state_q <= SCAN;
                        slot_q  <= '0;
                        deb_q   <= '0;
                    end else
`endif
                    if (!row_low) begin
                        state_q <= DEB_REL;
                        deb_q   <= '0;
                    end
                end
                DEB_REL: begin
                    if (row_low) begin
                        state_q <= HELD;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q  <= SCAN;
                        deb_q    <= '0;
                        slot_q   <= '0;
                        bstate_q <= 1'b0;
                        col_q    <= {col_q[2:0], col_q[3]};
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign col_n      = col_q;
    assign button     = button_q;
    assign bstate     = bstate_q;
    assign key_strobe = strobe_q;

endmodule
